// File: rtl/finv_pkg.sv
// Shared types and helpers for the reciprocal arbiter and its datapath.
// IEEE-754 single-precision field layout and the special-value encodings it needs.
package finv_pkg;

  localparam logic [7:0] FP_EXP_ZERO = 8'h00;
  localparam logic [7:0] FP_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  function automatic fp32_t fp_inf(input logic sign);
    fp_inf = '{sign: sign, exp: FP_EXP_MAX, man: 23'h0};
  endfunction

endpackage

// File: rtl/finv.sv
// Combinational single-precision reciprocal: truncated 1/x for normal operands.
// Results that would fall below the normal range flush to signed zero.
module finv
  import finv_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  localparam logic [47:0] DIV_NUM = 48'h8000_0000_0000;

  fp32_t             xf;
  fp32_t             yf;
  logic [22:0]       man_q;
  logic signed [9:0] exp_r;

  assign xf = fp32_t'(x);

  // 2^47 / {1,m} lands in [2^23, 2^24] so the low 23 bits are the fraction of 1/significand.
  always_comb begin
    man_q = 23'(DIV_NUM / {24'd0, 1'b1, xf.man});
    exp_r = ((xf.man == 23'h0) ? 10'sd254 : 10'sd253) - $signed({2'b00, xf.exp});
    yf    = '{sign: xf.sign, exp: exp_r[7:0], man: man_q};
    if (exp_r <= 10'sd0) begin
      yf = '{sign: xf.sign, exp: 8'h00, man: 23'h0};
    end
  end

  assign y = yf;

endmodule

// File: rtl/finv_arbiter.sv
// Round-robin sharing of one finv datapath among NREQ requesters, with a stage
// register in front of the datapath and a held result buffer per requester.
module finv_arbiter
  import finv_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [NREQ*32-1:0]   resp_y,
  output logic [NREQ-1:0]      resp_dz
);

  localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [TAG_W-1:0] tag_t;

  logic [NREQ-1:0]        busy;
  logic [NREQ-1:0]        eligible;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        consume;
  logic [NREQ-1:0][31:0]  req_x_a;
  logic [NREQ-1:0][31:0]  res_y;
  logic                   grant_any;
  tag_t                   grant_idx;
  tag_t                   last;

  logic                   s1_valid;
  tag_t                   s1_tag;
  fp32_t                  s1_x;
  logic [31:0]            dp_y;
  fp32_t                  s1_y;
  logic                   s1_dz;

  assign req_x_a   = req_x;
  assign eligible  = req_valid & ~busy;
  assign consume   = resp_valid & resp_ready;
  assign req_ready = grant;
  assign resp_y    = res_y;

  // Search starts just after the most recent grant, wrapping at NREQ.
  always_comb begin : rr_pick
    int idx;
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = tag_t'(idx);
      end
    end
  end

  finv u_finv (
    .x (s1_x),
    .y (dp_y)
  );

  // Zero and denormal divisors bypass the datapath with a signed infinity.
  always_comb begin
    s1_y  = fp32_t'(dp_y);
    s1_dz = 1'b0;
    if (s1_x.exp == FP_EXP_ZERO) begin
      s1_y  = fp_inf(s1_x.sign);
      s1_dz = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= '0;
      last       <= tag_t'(NREQ - 1);
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      s1_x       <= '0;
      resp_valid <= '0;
      resp_dz    <= '0;
      // NOTE: the result buffers are reset too, because resp_y must read zero out of reset and after an aborted operation.
      res_y      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here updates from the same pre-edge values.
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_tag <= grant_idx;
        s1_x   <= fp32_t'(req_x_a[grant_idx]);
        last   <= grant_idx;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          busy[i] <= 1'b1;
        end else if (consume[i]) begin
          busy[i] <= 1'b0;
        end
        if (s1_valid && (s1_tag == tag_t'(i))) begin
          resp_valid[i] <= 1'b1;
          res_y[i]      <= s1_y;
          resp_dz[i]    <= s1_dz;
        end else if (consume[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/finv_arbiter.md
# finv_arbiter

Shares one combinational reciprocal datapath (`finv`) between `NREQ` requesters using round-robin arbitration. Adds a pipeline register around the datapath, per-requester result buffers and valid/ready handshakes. Handles the zero-divisor case the datapath does not. Sits between the FPU issue ports and the single `finv` instance.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: requester i presents an operand.
- `req_ready` out NREQ: handshake accepted when `req_valid[i] & req_ready[i]`.
- `req_x` in NREQ×32: IEEE-754 single operands, packed, requester i at bits [32i+31:32i].
- `resp_valid` out NREQ: result for requester i is held.
- `resp_ready` in NREQ: requester i consumes its result.
- `resp_y` out NREQ×32: 1/x results, packed as `req_x`.
- `resp_dz` out NREQ: divide-by-zero flag qualifying `resp_y`.

## Operation
- **Per-requester state.** `busy[i]` is set on accept. It clears on the edge after `resp_valid[i] & resp_ready[i]`. At most one outstanding operation per requester.
- **Eligibility and grant.**
  - Requester i is eligible iff `req_valid[i] & !busy[i]`.
  - Each cycle at most one eligible requester is granted.
  - Search starts at `last+1` modulo NREQ. `last` is the index of the most recent grant.
  - `req_ready[i]` equals `grant[i]`, so it depends combinationally on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Stage S1** (registered on accept): `s1_valid`, `s1_tag` (index, clog2(NREQ) bits), `s1_x`.
- **Compute cycle.** While `s1_valid`, the datapath evaluates `s1_x` combinationally. On the next edge the result is written into `res_y[s1_tag]`, `res_dz[s1_tag]` is written, and `resp_valid[s1_tag]` is set.
- **Special cases**, decided in S1, overriding the datapath:
  - Exponent 0 (zero or denormal): y = {sign, 8'hFF, 23'h0}, dz=1.
  - Otherwise: datapath output unchanged, dz=0.
  - Exponent 255 inputs pass through the datapath. The result is not meaningful and there is no flag.
- **Response hold.** `resp_y`/`resp_dz` stay stable while `resp_valid[i]` is high and `resp_ready[i]` is low.
- **No structural stall.** S1 always drains in one cycle, and the result buffers are per-requester. A new grant is allowed every cycle.

## Timing
- **Latency.** Accept on edge T → `resp_valid` high after edge T+1, i.e. 2 cycles, visible during cycle T+1..T+2 boundary. Sustained throughput is 1 op/cycle across requesters. A single requester gets 1 op per 3 cycles minimum.
- **Reset values.**
  - Outputs: `req_ready`=0 (no grant possible while `busy` reset to 0 and `req_valid` low), `resp_valid`=0, `resp_y`=0, `resp_dz`=0.
  - Internal: `s1_valid`=0, `busy`=0, `last`=NREQ-1 so requester 0 wins first.
- **Consume and re-request in the same cycle.** `busy[i]` is still set, so `req_ready[i]`=0. The new request is accepted the following cycle at the earliest.
- **All requesters valid.** Grants rotate 0,1,…,NREQ-1 subject to busy. No requester waits more than NREQ-1 grants while eligible.
- **Reset mid-operation.** The S1 contents and held results are discarded. No `resp_valid` appears after reset deassertion for pre-reset requests.
- **`rstn` deassertion.** Synchronous release is the SoC's responsibility. The block makes no grant on the first edge where `rstn` is sampled high only if `req_valid` is low.

## Structure
- **Package `finv_pkg`:**
  - `FP_EXP_ZERO`=8'h00, `FP_EXP_MAX`=8'hFF.
  - Function `fp_inf(sign)`.
  - Typedef `fp32_t` (packed s/e/m struct).
- **Sub-modules.** One instance of the existing `finv` datapath, in the compute cycle. Round-robin arbitration stays inline: a priority rotate plus find-first, no separate module.

## Test plan
- **Single op, exact path.** Reset, then req0 `x`=0x40000000 → `resp_valid[0]` 2 cycles after accept. `resp_y[0]` equals the golden `finv` output for 0x40000000 (≈0x3F000000), dz=0.
- **Zero divisor.** req1 `x`=0x80000000 → `resp_y[1]`=0xFF800000, `resp_dz[1]`=1. Also `x`=0x00000001 (denormal) → 0x7F800000, dz=1.
- **Fairness.** NREQ=4, all valid continuously with `resp_ready`=1 → grant order 0,1,2,3,0,… Each requester gets one accept per 4 grants, and no `req_ready` while busy.
- **Backpressure.** Hold `resp_ready[0]`=0 for 10 cycles → `resp_y[0]` stable, `req_ready[0]`=0 throughout, other requesters keep being served. Release → busy clears one edge later.
- **Consume and re-request.** `resp_ready[0]` and the next `req_valid[0]` in the same cycle → `req_ready[0]`=0 that cycle, accepted the next cycle.
- **Reset mid-flight.** Assert `rstn`=0 while `s1_valid`=1 and `resp_valid[1]`=1 → all outputs 0 immediately. No stale response after release. Requester 0 is granted first.
